// File: rtl/pdm_playback_pkg.sv
// Shared constants for the PDM playback path: fetch FSM encoding, divider helper,
// modulator feedback magnitude and dither LFSR definition.
package pdm_playback_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  // x^16 + x^14 + x^13 + x^11, shifted left with the parity of the tapped bits.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int pdm_div(input int sys_hz, input int pdm_hz);
    return sys_hz / pdm_hz;
  endfunction

  function automatic int unsigned fb_mag(input int unsigned data_width);
    return 32'd1 << (data_width - 1);
  endfunction

endpackage

// File: rtl/pdm_playback_sigma_delta_mod.sv
// One channel of the 2nd-order sigma-delta modulator; advances only on ce and
// saturates both integrators at the signed ACC_WIDTH limits.
module sigma_delta_mod
  import pdm_playback_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         clr,
  input  logic                         ce,
  input  logic signed [DATA_WIDTH-1:0] x,
  input  logic signed [1:0]            dither,
  output logic                         pdm_bit
);

  // Two guard bits cover acc + acc + feedback without overflow.
  localparam int SW = ACC_WIDTH + 2;
  localparam logic signed [SW-1:0] ACC_MAX = {{(SW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] ACC_MIN = {{(SW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [SW-1:0] FB      = SW'(fb_mag(DATA_WIDTH));

  logic signed [ACC_WIDTH-1:0] i1, i2, i1_n, i2_n;
  logic signed [SW-1:0]        xe, fb, s1, s2;

  function automatic logic signed [ACC_WIDTH-1:0] sat(input logic signed [SW-1:0] v);
    if (v > ACC_MAX)      sat = ACC_MAX[ACC_WIDTH-1:0];
    else if (v < ACC_MIN) sat = ACC_MIN[ACC_WIDTH-1:0];
    else                  sat = v[ACC_WIDTH-1:0];
  endfunction

  always_comb begin
    xe   = SW'(x) + SW'(dither);
    fb   = pdm_bit ? FB : -FB;
    s1   = SW'(i1) + xe - fb;
    i1_n = sat(s1);
    s2   = SW'(i2) + SW'(i1_n) - fb;
    i2_n = sat(s2);
  end

  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      i1      <= '0;
      i2      <= '0;
      pdm_bit <= 1'b0;
    end else if (ce) begin
      i1      <= i1_n;
      i2      <= i2_n;
      pdm_bit <= !i2_n[ACC_WIDTH-1];
    end
  end

endmodule

// File: rtl/pdm_playback.sv
// PCM ping-pong buffer playback into per-channel PDM sigma-delta modulators.
// Optional PDM_PLAYBACK_DITHER_EN adds LFSR {-1,0,+1} dither ahead of the first integrator.
module pdm_playback
  import pdm_playback_pkg::*;
#(
  parameter int SYS_FREQ_HZ       = 150_000_000,
  parameter int PDM_FREQ_HZ       = 3_000_000,
  parameter int DATA_WIDTH        = 16,
  parameter int ADDR_WIDTH_BUFFER = 11,
  parameter int CHANNELS          = 2,
  parameter int CHANNELS_WIDTH    = $clog2(CHANNELS),
  parameter int ACC_WIDTH         = 24
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         enable,
  input  logic [DATA_WIDTH-1:0]        pdm_ratio,
  input  logic                         fill_done,
  input  logic                         fill_half,
  input  logic                         clear_underrun,
  output logic                         rd_en,
  output logic [ADDR_WIDTH_BUFFER-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         buffer_selector,
  output logic                         half_done,
  output logic                         underrun,
  output logic                         pdm_clk,
  output logic [CHANNELS-1:0]          pdm_data
);

  localparam int DIV    = pdm_div(SYS_FREQ_HZ, PDM_FREQ_HZ);
  localparam int DIV_W  = $clog2(DIV);
  localparam int FIDX_W = ADDR_WIDTH_BUFFER - 1 - CHANNELS_WIDTH;
  localparam logic [DIV_W-1:0]          HALF_DIV = DIV_W'(DIV / 2);
  localparam logic [DIV_W-1:0]          LAST_DIV = DIV_W'(DIV - 1);
  localparam logic [CHANNELS_WIDTH-1:0] LAST_CH  = CHANNELS_WIDTH'(CHANNELS - 1);

  logic [DIV_W-1:0]                      div_cnt;
  logic [DATA_WIDTH-1:0]                 ratio_q, frame_cnt;
  logic                                  pdm_tick, boundary, boundary_q;
  logic [1:0]                            state;
  logic [CHANNELS_WIDTH-1:0]             ch_cnt, rd_ch;
  logic [FIDX_W-1:0]                     frame_idx;
  logic                                  half, rd_pend, rd_zero, wrap_fetch;
  logic [1:0]                            valid;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0]   shadow, active;

  assign pdm_tick   = enable && (div_cnt == HALF_DIV);
  assign boundary   = pdm_tick && (frame_cnt == ratio_q);
  assign rd_en      = (state == ST_READ);
  assign rd_addr    = {half, frame_idx, ch_cnt};
  assign wrap_fetch = enable && rd_en && (ch_cnt == LAST_CH) && (&frame_idx);

  // pdm_clk is high for the first DIV/2 cycles of each period; the tick is its falling edge.
  always_ff @(posedge clk) begin
    if (!resetn || !enable) begin
      div_cnt    <= '0;
      pdm_clk    <= 1'b0;
      frame_cnt  <= '0;
      boundary_q <= 1'b0;
    end else begin
      div_cnt    <= (div_cnt == LAST_DIV) ? '0 : div_cnt + 1'b1;
      pdm_clk    <= (div_cnt < HALF_DIV);
      boundary_q <= boundary;
      if (pdm_tick) frame_cnt <= boundary ? '0 : frame_cnt + 1'b1;
    end
  end

  // Ratio tracks the input while idle so the first frame uses the programmed value.
  always_ff @(posedge clk) begin
    if (!resetn)                    ratio_q <= '0;
    else if (!enable || boundary)   ratio_q <= pdm_ratio;
  end

  always_ff @(posedge clk) begin
    if (!resetn || !enable) begin
      state           <= ST_IDLE;
      ch_cnt          <= '0;
      frame_idx       <= '0;
      half            <= 1'b0;
      rd_pend         <= 1'b0;
      rd_ch           <= '0;
      rd_zero         <= 1'b0;
      shadow          <= '0;
      active          <= '0;
      buffer_selector <= 1'b0;
      half_done       <= 1'b0;
    end else begin
      rd_pend   <= rd_en;
      rd_ch     <= ch_cnt;
      rd_zero   <= !valid[half];
      half_done <= wrap_fetch;
      if (rd_pend) shadow[rd_ch] <= rd_zero ? '0 : rd_data;
      if (boundary) begin
        active          <= shadow;
        buffer_selector <= half;
      end
      case (state)
        ST_IDLE: state <= ST_READ;
        ST_READ: begin
          ch_cnt <= ch_cnt + 1'b1;
          if (ch_cnt == LAST_CH) begin
            state     <= ST_WAIT;
            frame_idx <= frame_idx + 1'b1;
            if (&frame_idx) half <= !half;
          end
        end
        ST_WAIT: state <= ST_HOLD;
        ST_HOLD: if (boundary_q) state <= ST_READ;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Host fill beats the end-of-half clear; a fresh underrun beats clear_underrun.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid    <= '0;
      underrun <= 1'b0;
    end else begin
      for (int h = 0; h < 2; h++) begin
        if (fill_done && fill_half == 1'(h))     valid[h] <= 1'b1;
        else if (wrap_fetch && half == 1'(h))    valid[h] <= 1'b0;
      end
      if (enable && rd_en && !valid[half]) underrun <= 1'b1;
      else if (clear_underrun)             underrun <= 1'b0;
    end
  end

`ifdef PDM_PLAYBACK_DITHER_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk) begin
    if (!resetn || !enable) lfsr <= LFSR_SEED;
    else if (pdm_tick)      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic signed [1:0] dith;
`ifdef PDM_PLAYBACK_DITHER_EN
    logic [1:0] rb;
    assign rb   = lfsr[(2*c)%16 +: 2];
    assign dith = (rb == 2'b01) ? 2'sd1 : (rb == 2'b10) ? -2'sd1 : 2'sd0;
`else
    assign dith = 2'sd0;
`endif
    sigma_delta_mod #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_mod (
      .clk     (clk),
      .resetn  (resetn),
      .clr     (!enable),
      .ce      (pdm_tick),
      .x       (active[c]),
      .dither  (dith),
      .pdm_bit (pdm_data[c])
    );
  end

endmodule

// File: tb/tb_pdm_playback.sv
// Bench for pdm_playback: memory model, address scoreboard and PDM ones-density checks.
module tb_pdm_playback;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        resetn, enable, fill_done, fill_half, clear_underrun;
  logic [15:0] pdm_ratio;
  logic        rd_en;
  logic [4:0]  rd_addr;
  logic [15:0] rd_data = '0;
  logic        buffer_selector, half_done, underrun, pdm_clk;
  logic [1:0]  pdm_data;

  pdm_playback #(
    .SYS_FREQ_HZ       (12_000_000),
    .PDM_FREQ_HZ       (3_000_000),
    .ADDR_WIDTH_BUFFER (5)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .enable          (enable),
    .pdm_ratio       (pdm_ratio),
    .fill_done       (fill_done),
    .fill_half       (fill_half),
    .clear_underrun  (clear_underrun),
    .rd_en           (rd_en),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .buffer_selector (buffer_selector),
    .half_done       (half_done),
    .underrun        (underrun),
    .pdm_clk         (pdm_clk),
    .pdm_data        (pdm_data)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [32];
  logic [4:0]  mem_a;
  always @(posedge clk) begin
    if (rd_en) begin
      mem_a = rd_addr;
      #1 rd_data = mem[mem_a];
    end
  end

  int errors = 0, checks = 0;
  int tick, hd_cnt, ones0, ones1, highs;
  logic hd_half, prev_clk, meas, auto_refill, found;
  int exp_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic step();
    @(negedge clk);
    fill_done      = 1'b0;
    clear_underrun = 1'b0;
    if (half_done) begin
      hd_cnt++;
      if (auto_refill) begin
        fill_done = 1'b1;
        fill_half = hd_half;
      end
      hd_half = !hd_half;
    end
    if (pdm_clk && !prev_clk) begin
      tick++;
      if (meas) begin
        ones0 += int'(pdm_data[0]);
        ones1 += int'(pdm_data[1]);
      end
    end
    prev_clk = pdm_clk;
  endtask

  task automatic run_to(input int target);
    int lim, n;
    lim = (target - tick) * DIV * 2 + 100;
    n   = 0;
    while (tick < target && n < lim) begin
      step();
      n++;
    end
    if (tick < target) chk("tick_timeout", tick, target);
  endtask

  task automatic fill(input logic h);
    fill_done = 1'b1;
    fill_half = h;
    step();
  endtask

  // Fetch f, channel c lands at {half, idx, c} = (2f + c) mod 32 for 8 frames per half.
  task automatic start();
    exp_q.delete();
    for (int k = 0; k < 400; k++) exp_q.push_back(k % 32);
    tick = 0; hd_cnt = 0; hd_half = 1'b0; prev_clk = 1'b0;
    enable = 1'b1;
  endtask

  task automatic measure(input int from, input int to);
    run_to(from);
    ones0 = 0; ones1 = 0; meas = 1'b1;
    run_to(to);
    meas = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b1; pdm_ratio = 16'd63;
    fill_done = 1'b0; fill_half = 1'b0; clear_underrun = 1'b0;
    meas = 1'b0; auto_refill = 1'b0; tick = 0; prev_clk = 1'b0;
    hd_cnt = 0; hd_half = 1'b0; ones0 = 0; ones1 = 0;

    fork
      forever begin
        @(negedge clk);
        if (rd_en) begin
          if (exp_q.size() == 0) chk("rd_unexpected", rd_addr, -1);
          else chk("rd_addr", rd_addr, exp_q.pop_front());
        end
      end
    join_none

    // 1: reset with enable high, then idle after release
    repeat (4) step();
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_sel", buffer_selector, 0);
    chk("rst_half_done", half_done, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_pdm_clk", pdm_clk, 0);
    chk("rst_pdm_data", pdm_data, 0);
    enable = 1'b0; resetn = 1'b1;
    highs = 0;
    for (int i = 0; i < 20; i++) begin step(); highs += int'(pdm_clk); end
    chk("idle_pdm_clk_highs", highs, 0);

    // 2/3: both halves +16384 / -16384, addressing, half switch, density
    for (int a = 0; a < 32; a++) mem[a] = a[0] ? 16'hC000 : 16'h4000;
    fill(1'b0); fill(1'b1);
    auto_refill = 1'b1;
    start();
    run_to(300);
    chk("t3_sel_before_wrap", buffer_selector, 0);
    chk("t3_hd_before_wrap", hd_cnt, 0);
    run_to(586);
    chk("t3_half_done_once", hd_cnt, 1);
    chk("t3_sel_after_wrap", buffer_selector, 1);
    highs = 0;
    for (int i = 0; i < 40; i++) begin step(); highs += int'(pdm_clk); end
    chk("t2_pdm_clk_duty", highs, 20);
    measure(600, 4696);
    chk_range("t2_ch0_ones_75pct", ones0, 2949, 3195);
    chk_range("t2_ch1_ones_25pct", ones1, 901, 1147);
    enable = 1'b0;
    step();

    // 4: only half 0 filled; half 1 must play zeros and flag underrun
    resetn = 1'b0; step(); step(); resetn = 1'b1;
    for (int a = 16; a < 32; a++) mem[a] = 16'd20000;
    auto_refill = 1'b0;
    fill(1'b0);
    start();
    run_to(300);
    chk("t4_underrun_early", underrun, 0);
    run_to(640);
    chk("t4_underrun_set", underrun, 1);
    measure(640, 960);
    chk_range("t4_ch0_zero_50pct", ones0, 144, 176);
    chk_range("t4_ch1_zero_50pct", ones1, 144, 176);
    run_to(990);
    fill(1'b1); fill(1'b0);
    auto_refill = 1'b1;
    clear_underrun = 1'b1;
    step();
    chk("t4_underrun_cleared", underrun, 0);
    run_to(1502);
    chk("t4_no_new_underrun", underrun, 0);

    // 5: disable in the first READ cycle, then restart from address 0
    enable = 1'b0;
    step(); step();
    chk("t5_idle_pdm_clk", pdm_clk, 0);
    chk("t5_idle_pdm_data", pdm_data, 0);
    for (int a = 0; a < 32; a++) mem[a] = 16'h7FFF;
    fill(1'b0); fill(1'b1);
    start();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (rd_en) found = 1'b1;
    end
    chk("t5_first_rd_en", found, 1);
    enable = 1'b0;
    step();
    chk("t5_rd_en_dropped", rd_en, 0);
    chk("t5_pdm_data_zero", pdm_data, 0);
    chk("t5_pdm_clk_zero", pdm_clk, 0);
    step();

    // 6: full-scale positive input; saturation keeps density near 100%
    start();
    measure(200, 10200);
    chk_range("t6_ch0_fullscale", ones0, 9900, 10000);
    chk_range("t6_ch1_fullscale", ones1, 9900, 10000);
    enable = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
